// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and majority-vote sample phases.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_t;
    localparam int MAJ_OFS_LO = -1;
    localparam int MAJ_OFS_HI = 1;
    function automatic int maj_mid(input int os);
        return os / 2;
    endfunction
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: sample-tick divider, bit phase counter and 2-of-3 voter.
// done pulses on the last of the three mid-bit samples, with val holding the vote.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 1_600_000,
    parameter int BAUD_RATE   = 100_000,
    parameter int OVERSAMPLE  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic rx_s,
    output logic done,
    output logic val
);
    localparam int DIV_RAW = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int DW      = DIV > 1 ? $clog2(DIV) : 1;
    localparam int PW      = $clog2(OVERSAMPLE);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [PW-1:0] PH_LO    = PW'(maj_mid(OVERSAMPLE) + MAJ_OFS_LO);
    localparam logic [PW-1:0] PH_MID   = PW'(maj_mid(OVERSAMPLE));
    localparam logic [PW-1:0] PH_HI    = PW'(maj_mid(OVERSAMPLE) + MAJ_OFS_HI);
    localparam logic [PW-1:0] PH_LAST  = PW'(OVERSAMPLE - 1);

    logic [DW-1:0] div_cnt;
    logic [PW-1:0] phase;
    logic          s_lo, s_mid, tick;

    assign tick = div_cnt == DIV_LAST;
    assign done = tick && phase == PH_HI;
    assign val  = maj3(s_lo, s_mid, rx_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            phase   <= '0;
            s_lo    <= 1'b1;
            s_mid   <= 1'b1;
        end else if (clr) begin
            div_cnt <= '0;
            phase   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) phase <= phase == PH_LAST ? '0 : phase + 1'b1;
            if (tick && phase == PH_LO) s_lo <= rx_s;
            if (tick && phase == PH_MID) s_mid <= rx_s;
        end
    end
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver with valid/ready output and error pulses.
// Define UART_RX_PARITY_EN to add the parity_odd input and a parity bit check.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 1_600_000,
    parameter int BAUD_RATE   = 100_000,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
`ifdef UART_RX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 overrun,
    output logic                 busy
);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
    assign parity_error = 1'b0;
`endif

    rx_state_t            state;
    logic                 s1, s2, prev, done, val, start_edge, bad, stop_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] sh;

    assign start_edge = state == IDLE && prev && !s2;
    assign busy       = state != IDLE;

    uart_rx_oversample #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_os (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start_edge),
        .rx_s (s2),
        .done (done),
        .val  (val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            {s1, s2, prev} <= 3'b111;
            bit_cnt       <= '0;
            stop_cnt      <= 1'b0;
            bad           <= 1'b0;
            sh            <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
        end else begin
            {s1, s2, prev} <= {rx, s1, s2};
            framing_error <= 1'b0;
            overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            if (data_valid && data_ready) data_valid <= 1'b0;
            case (state)
                IDLE: if (start_edge) begin
                    state    <= START;
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    bad      <= 1'b0;
                end
                START: if (done) state <= val ? IDLE : DATA;
                DATA: if (done) begin
                    sh      <= {val, sh[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) state <= AFTER_DATA;
                end
`ifdef UART_RX_PARITY_EN
                // Keep consuming the frame after a parity miss so the stop bit is still checked.
                PARITY: if (done) begin
                    if ((^sh ^ val) != parity_odd) begin
                        parity_error <= 1'b1;
                        bad          <= 1'b1;
                    end
                    state <= STOP;
                end
`endif
                STOP: if (done) begin
                    if (!val) begin
                        framing_error <= 1'b1;
                        state         <= IDLE;
                    end else if (stop_cnt == STOP_LAST) begin
                        state <= IDLE;
                        if (!bad) begin
                            if (data_valid && !data_ready) overrun <= 1'b1;
                            else begin
                                data_out   <= sh;
                                data_valid <= 1'b1;
                            end
                        end
                    end else stop_cnt <= stop_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized frames against an event-queue scoreboard for two
// receiver configurations (8N1 default and 7-bit, two stop bits).
module tb_uart_rx_core;
    localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        int         kind;
        logic [8:0] d;
    } ev_t;

    logic       clk = 1'b0, rst_n = 1'b0, rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1, par_odd = 1'b0;
    logic [7:0] dout0;
    logic [6:0] dout1;
    logic       dv0, fe0, pe0, ov0, busy0, dv1, fe1, pe1, ov1, busy1;
    int         n_tests = 0, n_fail = 0;
    ev_t        q0[$], q1[$];
    bit         hold = 1'b0;
    logic [7:0] held;

    always #5 clk = ~clk;

    uart_rx_core dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0),
`ifdef UART_RX_PARITY_EN
        .parity_odd(par_odd),
`endif
        .data_out(dout0), .data_valid(dv0), .data_ready(rdy0),
        .framing_error(fe0), .parity_error(pe0), .overrun(ov0), .busy(busy0)
    );

    uart_rx_core #(.DATA_BITS(7), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1),
`ifdef UART_RX_PARITY_EN
        .parity_odd(par_odd),
`endif
        .data_out(dout1), .data_valid(dv1), .data_ready(rdy1),
        .framing_error(fe1), .parity_error(pe1), .overrun(ov1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // kind: 0 word accepted, 1 framing error, 2 parity error, 3 overrun
    task automatic got(input int sel, input int kind, input logic [8:0] d);
        ev_t e;
        int  sz;
        sz = sel ? q1.size() : q0.size();
        n_tests++;
        if (sz == 0) begin
            n_fail++;
            $display("FAIL unexpected_event dut%0d: got kind %0d data %0h, expected none", sel, kind, d);
            return;
        end
        if (sel) e = q1.pop_front();
        else e = q0.pop_front();
        if (e.kind != kind || (kind == 0 && e.d != d)) begin
            n_fail++;
            $display("FAIL event dut%0d: got kind %0d data %0h, expected kind %0d data %0h", sel, kind, d, e.kind, e.d);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (pe0) got(0, 2, 9'h0);
        if (fe0) got(0, 1, 9'h0);
        if (ov0) got(0, 3, 9'h0);
        if (dv0 && rdy0) got(0, 0, {1'b0, dout0});
        if (pe1) got(1, 2, 9'h0);
        if (fe1) got(1, 1, 9'h0);
        if (ov1) got(1, 3, 9'h0);
        if (dv1 && rdy1) got(1, 0, {2'b0, dout1});
    end

    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int sel, input int kind, input logic [8:0] d);
        ev_t e;
        e.kind = kind;
        e.d    = d;
        if (sel) q1.push_back(e);
        else q0.push_back(e);
    endtask

    task automatic set_ready0(input logic r);
        if (r && hold) begin
            push(0, 0, {1'b0, held});
            hold = 1'b0;
        end
        rdy0 = r;
    endtask

    // Reference model: frame rules decide which events the receiver must report.
    task automatic expect_frame(input int sel, input logic [8:0] d, input int bad_stop, input bit bad_par);
        bit good;
        good = bad_stop < 0 && !(PAR && bad_par);
        if (PAR && bad_par) push(sel, 2, 9'h0);
        if (bad_stop >= 0) push(sel, 1, 9'h0);
        if (good) begin
            if (sel) push(1, 0, d);
            else if (!rdy0 && hold) push(0, 3, 9'h0);
            else if (!rdy0) begin
                hold = 1'b1;
                held = d[7:0];
            end else push(0, 0, d);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel) rx1 = v;
        else rx0 = v;
    endtask

    task automatic send_frame(input int sel, input logic [8:0] d, input int nb, input int ns,
                              input int bad_stop, input bit bad_par);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nb; i++) p ^= d[i];
        p = p ^ par_odd ^ bad_par;
        set_line(sel, 1'b0);
        step(BIT);
        for (int i = 0; i < nb; i++) begin
            set_line(sel, d[i]);
            step(BIT);
        end
        if (PAR) begin
            set_line(sel, p);
            step(BIT);
        end
        for (int i = 0; i < ns; i++) begin
            set_line(sel, i != bad_stop);
            step(BIT);
        end
        set_line(sel, 1'b1);
    endtask

    task automatic frame(input int sel, input logic [8:0] d, input int bad_stop, input bit bad_par);
        expect_frame(sel, d, bad_stop, bad_par);
        if (sel) send_frame(1, d, 7, 2, bad_stop, bad_par);
        else send_frame(0, d, 8, 1, bad_stop, bad_par);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
            step(1);
            n++;
        end
        check("queues_drained", q0.size() + q1.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        check("reset_data_out", dout0, 0);
        check("reset_valid", dv0, 0);
        check("reset_busy", busy0, 0);
        check("reset_errors", {fe0, pe0, ov0}, 0);
        rst_n = 1'b1;
        step(5);

        set_ready0(1'b0);
        frame(0, 9'h55, -1, 1'b0);
        check("d55_valid", dv0, 1);
        check("d55_data", dout0, 8'h55);
        set_ready0(1'b1);
        step(4);

        set_ready0(1'b0);
        frame(0, 9'hA1, -1, 1'b0);
        frame(0, 9'hB2, -1, 1'b0);
        step(2);
        check("overrun_keeps_old", dout0, 8'hA1);
        check("overrun_valid", dv0, 1);
        set_ready0(1'b1);
        step(4);

        set_line(0, 1'b0);
        step(4);
        set_line(0, 1'b1);
        check("glitch_busy_start", busy0, 1);
        step(30);
        check("glitch_busy_idle", busy0, 0);
        check("glitch_valid", dv0, 0);

        rdy1 = 1'b0;
        frame(1, 9'h3A, 1, 1'b0);
        step(4);
        check("framing_no_valid", dv1, 0);
        rdy1 = 1'b1;
        step(4);
        for (int i = 0; i < 6; i++) begin
            int bs;
            bs = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 1)) : -1;
            frame(1, 9'($urandom_range(0, 127)), bs, 1'b0);
            step(bs >= 0 ? 4 + int'($urandom_range(0, 8)) : int'($urandom_range(0, 8)));
        end

`ifdef UART_RX_PARITY_EN
        par_odd = 1'b0;
        frame(0, 9'h07, -1, 1'b1);
        step(4);
        check("parity_discard", dv0, 0);
`endif

        for (int i = 0; i < 24; i++) begin
            int bs;
            bit bp;
            set_ready0(1'($urandom_range(0, 1)));
            if (PAR) par_odd = 1'($urandom_range(0, 1));
            bs = $urandom_range(0, 5) == 0 ? 0 : -1;
            bp = $urandom_range(0, 4) == 0;
            frame(0, 9'($urandom_range(0, 255)), bs, bp);
            step(bs >= 0 ? 4 + int'($urandom_range(0, 8)) : int'($urandom_range(0, 8)));
        end
        set_ready0(1'b1);
        step(4);
        drain();

        set_line(0, 1'b0);
        step(BIT);
        for (int i = 0; i < 4; i++) begin
            set_line(0, 1'b1);
            step(BIT);
        end
        step(BIT / 2);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy0, 0);
        check("midreset_valid", dv0, 0);
        check("midreset_data", dout0, 0);
        step(3);
        rst_n = 1'b1;
        step(20);
        frame(0, 9'h12, -1, 1'b0);
        check("after_reset_data", dout0, 8'h12);
        step(4);
        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 1_600_000, system clock frequency.
REQ-002 SHALL have parameter BAUD_RATE, default 100_000, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; even, 8..32.
REQ-004 SHALL have parameter DATA_BITS, default 8, payload width; legal 5..9.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal 1..2.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-009 SHALL have port data_out  output  DATA_BITS  received word, LSB = first bit on line.
REQ-010 SHALL have port data_valid  output  1  data_out holds an unconsumed word.
REQ-011 SHALL have port data_ready  input  1  consumer accepts word when high with data_valid.
REQ-012 SHALL have port framing_error  output  1  one-cycle pulse: a stop bit was sampled low.
REQ-013 SHALL have port parity_error  output  1  one-cycle pulse: parity mismatch; tied 0 without UART_RX_PARITY_EN.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse: word completed while data_valid was high and data_ready low.
REQ-015 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-016 SHALL synchronise rx through two flops, reset-preset to 1, before any use.
REQ-017 SHALL derive the sample tick internally: one tick every CLK_FREQ_HZ/(BAUD_RATE*OVERSAMPLE) clocks, integer division; the counter restarts on start-edge detection.
REQ-018 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL move from IDLE to START on the synchronised 1->0 edge, with the tick phase counter cleared.
REQ-020 SHALL resolve each bit by 2-of-3 majority over the ticks at phases OVERSAMPLE/2-1, OVERSAMPLE/2, and OVERSAMPLE/2+1.
REQ-021 SHALL treat a START bit that resolves to 1 as a glitch: return to IDLE, assert no error, set no flag.
REQ-022 SHALL shift DATA_BITS bits LSB-first in DATA, then go to PARITY (macro on) or STOP.
REQ-023 SHALL check STOP_BITS stop bits in STOP; any stop bit resolving 0 pulses framing_error and discards the word; the FSM then returns to IDLE.
REQ-024 SHALL, on a good frame, load data_out and set data_valid on the clock after the last stop-bit decision.
REQ-025 SHALL hold data_out/data_valid stable until data_valid&&data_ready; data_valid clears on the next clock.
REQ-026 SHALL, when a good word completes while data_valid&&!data_ready, pulse overrun, keep the old word, and drop the new one.
REQ-027 SHALL, when a word completes in the same cycle as an accept, load the new word with data_valid staying high and no overrun.
REQ-028 SHALL re-arm for a start edge on the cycle IDLE is re-entered, so back-to-back frames are received.

Reset
REQ-029 SHALL, on rst_n low, immediately force state=IDLE, counters=0, sync flops=1, data_out=0, data_valid=0, framing_error=0, parity_error=0, overrun=0, busy=0.
REQ-030 SHALL, on reset mid-frame, abandon the partial word; the first frame accepted after release starts from a fresh start edge.

Configuration
REQ-031 SHALL, with macro UART_RX_PARITY_EN defined, add input parity_odd (1 = odd, 0 = even) and a PARITY state that samples one bit after the data; on mismatch, pulse parity_error and discard the word.
REQ-032 SHALL, without UART_RX_PARITY_EN, omit the parity_odd port and the PARITY state, and tie parity_error to 0.

Structure
REQ-033 SHALL place the FSM state encoding and the majority-phase constants in shared package uart_pkg.
REQ-034 SHALL implement the tick counter plus 2-of-3 voter as sub-module uart_rx_oversample.

Verification
REQ-035 SHALL verify: default parameters, frame 0x55 with 1 stop bit -> data_out=0x55, data_valid high within 1 clock of the stop decision, no error pulses.
REQ-036 SHALL verify: DATA_BITS=7, STOP_BITS=2, frame 0x3A with the second stop bit low -> framing_error pulses 1 cycle and data_valid stays 0.
REQ-037 SHALL verify: data_ready held 0, frames 0xA1 then 0xB2 -> overrun pulses once and data_out=0xA1 remains.
REQ-038 SHALL verify: rx low for 4 clocks only (< half bit) -> return to IDLE, busy low after START, no outputs change.
REQ-039 SHALL verify: UART_RX_PARITY_EN, parity_odd=0, frame 0x07 with parity bit 0 -> parity_error pulses and the word is discarded.
REQ-040 SHALL verify: rst_n asserted at data bit 4 of 0xFF, then frame 0x12 -> data_out=0x12 with no stale bits.
